// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract |B|, insert quotient bit.
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] b_ext;

  always_comb begin
    r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
    b_ext   = {1'b0, b};
    r_next  = r_shift;
    q_next  = {q[WIDTH-2:0], 1'b0};
    // A set top bit means the shifted remainder already exceeds any divisor.
    if (r[WIDTH] || (r_shift >= b_ext)) begin
      r_next    = r_shift - b_ext;
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div.sv
// Sequential signed divider: magnitudes are divided one bit per clock, signs fixed up in DONE.
module div
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] regA_out,
  input  logic [WIDTH-1:0] regB_out,
  input  logic             divControl,
  output logic             finalDiv,
  output logic             divZero,
  output logic [WIDTH-1:0] hi_entrance,
  output logic [WIDTH-1:0] lo_entrance
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sa_reg;
  logic             sb_reg;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    a_mag = regA_out[WIDTH-1] ? (WIDTH'(0) - regA_out) : regA_out;
    b_mag = regB_out[WIDTH-1] ? (WIDTH'(0) - regB_out) : regB_out;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .b      (b_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      b_reg       <= '0;
      sa_reg      <= 1'b0;
      sb_reg      <= 1'b0;
      finalDiv    <= 1'b0;
      divZero     <= 1'b0;
      hi_entrance <= '0;
      lo_entrance <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          finalDiv <= 1'b0;
          if (divControl) begin
            sa_reg    <= regA_out[WIDTH-1];
            sb_reg    <= regB_out[WIDTH-1];
            b_reg     <= b_mag;
            q_reg     <= a_mag;
            r_reg     <= '0;
            cnt_reg   <= '0;
            divZero   <= 1'b0;
            state_reg <= (regB_out == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!divControl) begin
            state_reg <= IDLE;
          end else begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ITER) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          finalDiv <= 1'b1;
          if (b_reg == '0) begin
            divZero <= 1'b1;
          end else begin
            lo_entrance <= (sa_reg ^ sb_reg) ? (WIDTH'(0) - q_reg) : q_reg;
            hi_entrance <= sa_reg ? (WIDTH'(0) - r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
          end
          state_reg <= WAIT;
        end
        WAIT: begin
          // Hold here until the control unit releases the request, so one request yields one result.
          finalDiv <= 1'b0;
          if (!divControl) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Randomized scoreboard bench for the signed divider against an arithmetic reference model.
module tb_div;
  import muldiv_pkg::*;

  localparam int W = DATA_W;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] regA_out = '0;
  logic [W-1:0] regB_out = '0;
  logic         divControl = 1'b0;
  logic         finalDiv;
  logic         divZero;
  logic [W-1:0] hi_entrance;
  logic [W-1:0] lo_entrance;

  always #5 clock = ~clock;

  div #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .regA_out    (regA_out),
    .regB_out    (regB_out),
    .divControl  (divControl),
    .finalDiv    (finalDiv),
    .divZero     (divZero),
    .hi_entrance (hi_entrance),
    .lo_entrance (lo_entrance)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  int           pass_cnt  = 0;
  int           total_cnt = 0;
  logic [W-1:0] model_hi  = '0;
  logic [W-1:0] model_lo  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: truncating signed division; hi/lo retained on divide-by-zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint la, lb, lq, lr;
    if (b == '0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
    end else begin
      la   = longint'($signed(a));
      lb   = longint'($signed(b));
      lq   = la / lb;
      lr   = la % lb;
      e.lo = lq[W-1:0];
      e.hi = lr[W-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every finalDiv pulse must match the oldest expected result.
  always @(negedge clock) begin
    exp_t e;
    if (reset && finalDiv === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_finalDiv", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("lo", {32'd0, lo_entrance}, {32'd0, e.lo});
        check("hi", {32'd0, hi_entrance}, {32'd0, e.hi});
        check("divZero", {63'd0, divZero}, {63'd0, e.dz});
        $display("txn lo=%08h hi=%08h divZero=%0b (exp lo=%08h hi=%08h dz=%0b)",
                 lo_entrance, hi_entrance, divZero, e.lo, e.hi, e.dz);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int   n;
    int   extra;
    bit   seen;
    @(negedge clock);
    regA_out   = a;
    regB_out   = b;
    divControl = 1'b1;
    e = model(a, b);
    sb_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    @(posedge clock);
    #1;
    regA_out = $urandom;
    regB_out = $urandom;
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clock);
      n++;
      if (finalDiv === 1'b1) seen = 1'b1;
    end
    check("latency", 64'(n), (b == '0) ? 64'd2 : 64'd34);
    extra = 0;
    repeat (hold) begin
      @(negedge clock);
      if (finalDiv !== 1'b0) extra++;
    end
    check("single_pulse", 64'(extra), 64'd0);
    divControl = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic abort_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int pulses;
    @(negedge clock);
    regA_out   = a;
    regB_out   = b;
    divControl = 1'b1;
    @(posedge clock);
    repeat (5) @(posedge clock);
    @(negedge clock);
    divControl = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (finalDiv !== 1'b0) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    check("abort_lo", {32'd0, lo_entrance}, {32'd0, model_lo});
    check("abort_hi", {32'd0, hi_entrance}, {32'd0, model_hi});
  endtask

  task automatic reset_mid_run(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    regA_out   = a;
    regB_out   = b;
    divControl = 1'b1;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst_lo", {32'd0, lo_entrance}, 64'd0);
    check("rst_hi", {32'd0, hi_entrance}, 64'd0);
    check("rst_finalDiv", {63'd0, finalDiv}, 64'd0);
    check("rst_divZero", {63'd0, divZero}, 64'd0);
    model_hi   = '0;
    model_lo   = '0;
    divControl = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           mode;
    repeat (2) @(negedge clock);
    check("reset_lo", {32'd0, lo_entrance}, 64'd0);
    check("reset_hi", {32'd0, hi_entrance}, 64'd0);
    check("reset_finalDiv", {63'd0, finalDiv}, 64'd0);
    check("reset_divZero", {63'd0, divZero}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    do_op(32'd7, 32'd2, 1);
    do_op(32'hFFFF_FFF9, 32'd2, 1);
    do_op(32'd7, 32'hFFFF_FFFE, 1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1);
    do_op(32'h8000_0000, 32'd1, 1);
    do_op(32'd1234, 32'd55, 1);
    do_op(32'd5, 32'd0, 1);
    do_op(32'd9, 32'd4, 1);

    reset_mid_run(32'd100, 32'd3);
    do_op(32'd100, 32'd3, 1);

    abort_op(32'd100, 32'd3);
    do_op(32'd100, 32'd3, 6);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      ra   = (mode == 0) ? W'($urandom_range(0, 200)) : W'($urandom);
      case (mode)
        0:       rb = '0;
        1:       rb = $urandom_range(0, 1) ? W'($urandom_range(1, 20)) : (W'(0) - W'($urandom_range(1, 20)));
        default: rb = $urandom;
      endcase
      do_op(ra, rb, $urandom_range(1, 3));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
